sb_cfg: RTL and testbench

Parametrised, runtime-configurable switch box for the FPGA routing fabric. Each of `W` output tracks selects one of `FANIN` input tracks, or is driven low. Selects come from an internal configuration register, not from top-level pins. That register is loaded serially through a daisy-chainable shift chain into a shadow copy, then committed atomically to the active copy, so routing never glitches mid-load.

---
 rtl/sb_cfg.sv | 148 ++++++++++++++
 tb/tb_sb_cfg.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sb_cfg.sv
// sb_cfg: configurable routing switch box with a serial shadow/active
// config chain; each output track picks one of FANIN taps or is off.
module sb_cfg #(
  parameter int W       = 8,
  parameter int FANIN   = 3,
  parameter int OFFS    = 3,
  parameter int REG_OUT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in,
  output logic [W-1:0] out,
  input  logic         cfg_in,
  input  logic         cfg_en,
  input  logic         cfg_commit,
  output logic         cfg_out,
  output logic         cfg_full,
  output logic         cfg_err
);

  localparam int SELW     = $clog2(FANIN + 1);
  localparam int CFG_BITS = W * SELW;
  localparam int CW       = $clog2(CFG_BITS + 1);

  localparam logic [CW-1:0] CNT_MAX  = CW'(CFG_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CFG_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ARMED
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CFG_BITS-1:0] r_shadow;
  logic [CFG_BITS-1:0] r_active;
  logic [CW-1:0]       r_cnt;
  logic                r_err;
  logic                w_accept;
  logic [W-1:0]        w_route;

  assign w_accept = cfg_commit & ~cfg_en & (r_state == S_ARMED);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (cfg_en)
          w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (cfg_en && r_cnt == CNT_LAST)
          w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (w_accept)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (cfg_en && r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (cfg_en) begin
      r_shadow <= {r_shadow[CFG_BITS-2:0], cfg_in};
    end
  end

  // all-ones reset decodes every select as off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= '1;
    end else if (w_accept) begin
      r_active <= r_shadow;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= cfg_commit & ~w_accept;
    end
  end

  assign cfg_out  = r_shadow[CFG_BITS-1];
  assign cfg_full = (r_state == S_ARMED);
  assign cfg_err  = r_err;

  for (genvar gi = 0; gi < W; gi++) begin : g_out
    logic [FANIN-1:0] w_cand;
    logic [SELW-1:0]  w_sel;
    logic             w_bit;

    assign w_sel = r_active[SELW*gi +: SELW];

    for (genvar gk = 0; gk < FANIN; gk++) begin : g_tap
      localparam int TAP = (gi + OFFS * (gk + 1)) % W;
      assign w_cand[gk] = in[TAP];
    end

    always_comb begin
      w_bit = 1'b0;
      for (int k = 0; k < FANIN; k++) begin
        if (w_sel == SELW'(k))
          w_bit = w_cand[k];
      end
    end

    assign w_route[gi] = w_bit;
  end

  if (REG_OUT != 0) begin : g_reg
    logic [W-1:0] r_out;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_out <= '0;
      end else begin
        r_out <= w_route;
      end
    end
    assign out = r_out;
  end else begin : g_comb
    assign out = w_route;
  end

endmodule

// File: tb/tb_sb_cfg.sv
// tb_sb_cfg: table vectors plus scoreboard for sb_cfg routing,
// commit rules, daisy chaining and registered output.
module tb_sb_cfg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] a_in, r_in;
  logic [7:0] a_out, b_out, r_out;
  logic       cfg_in = 1'b0;
  logic       cfg_en = 1'b0;
  logic       cfg_commit = 1'b0;
  logic       a_co, a_full, a_err;
  logic       b_co, b_full, b_err;
  logic       r_co, r_full, r_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sb_cfg u_a (
    .clk(clk), .rst_n(rst_n), .in(a_in), .out(a_out),
    .cfg_in(cfg_in), .cfg_en(cfg_en), .cfg_commit(cfg_commit),
    .cfg_out(a_co), .cfg_full(a_full), .cfg_err(a_err)
  );

  sb_cfg u_b (
    .clk(clk), .rst_n(rst_n), .in(a_in), .out(b_out),
    .cfg_in(a_co), .cfg_en(cfg_en), .cfg_commit(cfg_commit),
    .cfg_out(b_co), .cfg_full(b_full), .cfg_err(b_err)
  );

  sb_cfg #(.REG_OUT(1)) u_r (
    .clk(clk), .rst_n(rst_n), .in(r_in), .out(r_out),
    .cfg_in(cfg_in), .cfg_en(cfg_en), .cfg_commit(cfg_commit),
    .cfg_out(r_co), .cfg_full(r_full), .cfg_err(r_err)
  );

  typedef struct {
    string      nm;
    logic [7:0] exp;
  } sb_t;

  typedef struct {
    logic [15:0] word;
    logic [7:0]  din;
    logic [7:0]  exp;
  } vec_t;

  sb_t  sbq[$];
  vec_t vt[6];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input string nm, input logic [7:0] e);
    sb_t s;
    s.nm  = nm;
    s.exp = e;
    sbq.push_back(s);
  endtask

  task automatic pop(input logic [7:0] act);
    sb_t s;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got %h want none", act);
    end else begin
      s = sbq.pop_front();
      chk(s.nm, 16'(act), 16'(s.exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_n(input logic [31:0] w, input int n);
    for (int b = n - 1; b >= 0; b--) begin
      cfg_in = w[b];
      cfg_en = 1'b1;
      step();
    end
    cfg_en = 1'b0;
    cfg_in = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
  endtask

  initial begin
    vt[0] = '{16'h5555, 8'h01, 8'h04};
    vt[1] = '{16'hAAAA, 8'h01, 8'h80};
    vt[2] = '{16'hFFFF, 8'h01, 8'h00};
    vt[3] = '{16'h1B1B, 8'hA5, 8'h86};
    vt[4] = '{16'h1B1B, 8'hFF, 8'hEE};
    vt[5] = '{16'h0000, 8'h01, 8'h20};

    // asynchronous reset mid-cycle with all inputs high
    a_in = 8'hFF;
    r_in = 8'hFF;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_out", 16'(a_out), 16'h00);
    chk("rst_rout", 16'(r_out), 16'h00);
    chk("rst_full", 16'(a_full), 16'h0);
    chk("rst_cfgout", 16'(a_co), 16'h0);
    chk("rst_err", 16'(a_err), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      shift_n({16'h0, vt[i].word}, 16);
      chk($sformatf("full%0d", i), 16'(a_full), 16'h1);
      chk($sformatf("cfgout%0d", i), 16'(a_co), 16'(vt[i].word[15]));
      commit();
      chk($sformatf("full_clr%0d", i), 16'(a_full), 16'h0);
      chk($sformatf("err%0d", i), 16'(a_err), 16'h0);
      a_in = vt[i].din;
      push($sformatf("route%0d", i), vt[i].exp);
      #1;
      pop(a_out);
    end

    // early commit after 10 bits
    shift_n(32'h3FF, 10);
    chk("early_full", 16'(a_full), 16'h0);
    commit();
    chk("early_err", 16'(a_err), 16'h1);
    chk("early_full2", 16'(a_full), 16'h0);
    push("early_keep", 8'h20);
    pop(a_out);
    step();
    chk("early_err_pulse", 16'(a_err), 16'h0);
    shift_n(32'h3F, 6);
    chk("early_full3", 16'(a_full), 16'h1);
    commit();
    chk("early_acc_err", 16'(a_err), 16'h0);
    chk("early_acc_full", 16'(a_full), 16'h0);
    push("early_off", 8'h00);
    pop(a_out);

    // commit together with a shift is rejected, shift still happens
    shift_n(32'h5555, 16);
    chk("cws_full", 16'(a_full), 16'h1);
    cfg_commit = 1'b1;
    cfg_en = 1'b1;
    cfg_in = 1'b0;
    step();
    cfg_commit = 1'b0;
    cfg_en = 1'b0;
    chk("cws_err", 16'(a_err), 16'h1);
    chk("cws_full2", 16'(a_full), 16'h1);
    chk("cws_cfgout", 16'(a_co), 16'h1);
    push("cws_keep", 8'h00);
    pop(a_out);
    commit();
    chk("cws_acc_full", 16'(a_full), 16'h0);
    chk("cws_acc_err", 16'(a_err), 16'h0);
    push("cws_route", 8'h80);
    pop(a_out);

    // daisy chain: B word first, then A word
    shift_n({16'hAAAA, 16'h5555}, 32);
    chk("chain_afull", 16'(a_full), 16'h1);
    chk("chain_bfull", 16'(b_full), 16'h1);
    commit();
    chk("chain_berr", 16'(b_err), 16'h0);
    a_in = 8'h01;
    push("chain_a", 8'h04);
    push("chain_b", 8'h80);
    #1;
    pop(a_out);
    pop(b_out);

    // registered output, one-cycle latency
    r_in = 8'h00;
    shift_n(32'h0, 16);
    commit();
    step();
    chk("reg_idle", 16'(r_out), 16'h00);
    r_in = 8'h01;
    push("reg_hold0", 8'h00);
    push("reg_a", 8'h20);
    #1;
    pop(r_out);
    step();
    pop(r_out);
    r_in = 8'h02;
    push("reg_hold1", 8'h20);
    push("reg_b", 8'h40);
    #1;
    pop(r_out);
    step();
    pop(r_out);

    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_leftover: got %0d want 0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
